// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of an 8N1 serial transmitter.
// CPU stores push bytes at full speed; the transmitter pops and shifts them
// out LSB first at CLKS_PER_BIT clocks per bit, back to back when queued.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    wdata,
    input  logic                          wen,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BC_W  = $clog2(CLKS_PER_BIT);

    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [BC_W-1:0]  bc;
    logic [BC_W-1:0]  bc_nxt;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;
    logic [7:0]       shift;
    logic [7:0]       shift_nxt;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count_nxt;
    logic             full_nxt;
    logic             tx_nxt;
    logic             busy_nxt;

    // A store is accepted only when the FIFO was not full before the edge,
    // regardless of a same-cycle pop.
    assign push = wen & ~full;

    // FIFO storage; no reset needed, occupancy governs validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Transmit FSM next state, baud counter, bit index and pop request.
    always_comb begin
        state_nxt = state;
        bc_nxt    = bc;
        idx_nxt   = idx;
        shift_nxt = shift;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    bc_nxt    = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bc == BC_LAST) begin
                    bc_nxt    = '0;
                    idx_nxt   = '0;
                    state_nxt = DATA;
                end else begin
                    bc_nxt = bc + BC_W'(1);
                end
            end
            DATA: begin
                if (bc == BC_LAST) begin
                    bc_nxt = '0;
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end else begin
                    bc_nxt = bc + BC_W'(1);
                end
            end
            STOP: begin
                if (bc == BC_LAST) begin
                    bc_nxt = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (count != '0) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    bc_nxt = bc + BC_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Occupancy bookkeeping and next values of the registered outputs.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
        full_nxt = (count_nxt == CNT_FULL);
        busy_nxt = (state_nxt != IDLE) || (count_nxt != '0);
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[idx_nxt];
            default: tx_nxt = 1'b1;
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bc       <= '0;
            idx      <= '0;
            shift    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            bc       <= bc_nxt;
            idx      <= idx_nxt;
            shift    <= shift_nxt;
            count    <= count_nxt;
            full     <= full_nxt;
            busy     <= busy_nxt;
            tx       <= tx_nxt;
            overflow <= overflow | (wen & full);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-level reference model, per-cycle output
// checks, and a serial receiver that scores decoded frames against a queue.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wen;
    logic [7:0] wdata;
    logic       tx;
    logic       busy;
    logic       full;
    logic [2:0] count;
    logic       overflow;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wdata    (wdata),
        .wen      (wen),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the number of line cycles left in
    // the current frame (0 = line idle). A frame always lasts FRAME cycles.
    logic [7:0] mq[$];
    logic [7:0] sb_q[$];
    int         m_tx_left = 0;
    logic [7:0] m_cur = 8'h00;
    bit         m_ovf = 1'b0;
    bit         m_valid = 1'b0;
    int         m_sz;
    bit         m_push;
    bit         m_pop;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            sb_q.delete();
            m_tx_left = 0;
            m_ovf     = 1'b0;
            m_valid   = 1'b1;
        end else begin
            m_sz   = mq.size();
            m_push = wen && (m_sz < DEPTH);
            if (wen && m_sz >= DEPTH) m_ovf = 1'b1;
            m_pop  = (m_sz > 0) && (m_tx_left <= 1);
            if (m_pop) begin
                m_cur     = mq.pop_front();
                m_tx_left = FRAME;
            end else if (m_tx_left > 0) begin
                m_tx_left--;
            end
            if (m_push) begin
                mq.push_back(wdata);
                sb_q.push_back(wdata);
            end
        end
    end

    function automatic logic exp_tx();
        int b;
        if (m_tx_left == 0) return 1'b1;
        b = (FRAME - m_tx_left) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    // Per-cycle comparison of all registered outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("tx",       8'(tx),       8'(exp_tx()));
            chk("count",    8'(count),    8'(mq.size()));
            chk("full",     8'(full),     8'(mq.size() == DEPTH));
            chk("busy",     8'(busy),     8'((m_tx_left > 0) || (mq.size() > 0)));
            chk("overflow", 8'(overflow), 8'(m_ovf));
        end
    end

    // Serial receiver: mid-bit sampling, scored against bytes accepted by the model.
    bit         rx_on = 1'b0;
    int         rx_cnt = 0;
    logic [9:0] rx_bits;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_on = 1'b0;
        end else begin
            if (!rx_on) begin
                if (tx === 1'b0) begin
                    rx_on  = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
            end
            if (rx_on && (rx_cnt % CPB) == CPB / 2) begin
                rx_bits[rx_cnt / CPB] = tx;
                if (rx_cnt / CPB == 9) begin
                    rx_on = 1'b0;
                    chk("start_bit", 8'(rx_bits[0]), 8'h00);
                    chk("stop_bit",  8'(rx_bits[9]), 8'h01);
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL frame: got byte %0h expected no frame at t=%0t", rx_bits[8:1], $time);
                    end else begin
                        chk("frame_byte", rx_bits[8:1], sb_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input bit w, input logic [7:0] d, input bit r);
        wen   = w;
        wdata = d;
        rst_n = ~r;
        @(posedge clk);
        #1;
        wen   = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (((m_tx_left > 0) || (mq.size() > 0)) && n < limit) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        n_vec++;
        if (n >= limit) begin
            n_bad++;
            $display("FAIL drain: got still busy after %0d cycles expected idle", n);
        end
        repeat (FRAME) step(1'b0, 8'h00, 1'b0);
        chk("sb_empty", 8'(sb_q.size()), 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rate;
        rst_n = 1'b0;
        wen   = 1'b0;
        wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        chk("rst_tx",       8'(tx),       8'h01);
        chk("rst_busy",     8'(busy),     8'h00);
        chk("rst_full",     8'(full),     8'h00);
        chk("rst_count",    8'(count),    8'h00);
        chk("rst_overflow", 8'(overflow), 8'h00);

        // single byte: start bit one cycle after the push edge, idle after 41 edges
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("t1_tx_low", 8'(tx), 8'h00);
        repeat (40) step(1'b0, 8'h00, 1'b0);
        chk("t1_busy_done", 8'(busy), 8'h00);
        chk("t1_sb_empty",  8'(sb_q.size()), 8'h00);

        // two bytes back to back
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        drain(4 * FRAME);

        // burst of six: fifth fills the FIFO, sixth overflows
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        chk("t3_full",     8'(full),     8'h01);
        chk("t3_overflow", 8'(overflow), 8'h01);
        drain(8 * FRAME);

        // push during the pop cycle of a full FIFO is dropped
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        chk("t4_full",    8'(full),     8'h01);
        chk("t4_no_ovf",  8'(overflow), 8'h00);
        n = 0;
        while (!(m_tx_left == 1 && mq.size() == DEPTH) && n < 4 * FRAME) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk("t4_reached", 8'(n < 4 * FRAME), 8'h01);
        step(1'b1, 8'h77, 1'b0);
        chk("t4_count",    8'(count),    8'(DEPTH - 1));
        chk("t4_overflow", 8'(overflow), 8'h01);
        drain(8 * FRAME);

        // reset during the third data bit with two bytes queued
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        n = 0;
        while ((FRAME - m_tx_left) / CPB != 3 && n < 2 * FRAME) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk("t5_reached", 8'(n < 2 * FRAME), 8'h01);
        step(1'b0, 8'h00, 1'b1);
        chk("t5_tx",       8'(tx),       8'h01);
        chk("t5_count",    8'(count),    8'h00);
        chk("t5_busy",     8'(busy),     8'h00);
        chk("t5_overflow", 8'(overflow), 8'h00);

        // quiet line after reset
        repeat (100) step(1'b0, 8'h00, 1'b0);
        chk("t6_tx",   8'(tx),   8'h01);
        chk("t6_busy", 8'(busy), 8'h00);

        // random traffic with alternating light and heavy load, rare resets
        for (int i = 0; i < 3000; i++) begin
            rate = ((i / 500) % 2 == 1) ? 70 : 6;
            step($urandom_range(0, 99) < rate, 8'($urandom), $urandom_range(0, 999) == 0);
        end
        drain(FRAME * (DEPTH + 2) + 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
